keypad_scanner: RTL and testbench

Scans a 4x4 matrix keypad, debounces it, and encodes the pressed key. Each accepted keystroke goes into a small FIFO exposed to the PicoBlaze input mux as a data/present/ack triple, with the same handshake as the UART receive path. It sits upstream of the CPU I/O routing: `key_code` feeds input port 0x06, and `key_present` feeds a status port. It replaces free-running column counting and per-port key decoding in the top level.

---
 rtl/keypad_pkg.sv | 39 +++
 rtl/keypad_fifo.sv | 54 +++++
 rtl/keypad_scanner.sv | 183 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types, constants and helpers for the 4x4 keypad scanner.
//   scan_state_t   : column scan sequencer states
//   key_state_t    : keystroke acceptance states
//   KEY_CODE_W     : width of an encoded key code
//   NO_KEY         : code presented when no keystroke is buffered
//   onehot16_index : bit position of the single set bit in a sweep snapshot
//   is_onehot16    : true when exactly one bit of a sweep snapshot is set
package keypad_pkg;

    typedef enum logic [1:0] {
        DRIVE,
        SAMPLE,
        EVAL
    } scan_state_t;

    typedef enum logic {
        IDLE,
        HELD
    } key_state_t;

    localparam int unsigned KEY_CODE_W = 8;
    localparam logic [KEY_CODE_W-1:0] NO_KEY = 8'h00;

    // Only meaningful when is_onehot16(v) holds.
    function automatic logic [3:0] onehot16_index(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // Clearing the lowest set bit leaves zero only for a single set bit.
    function automatic logic is_onehot16(input logic [15:0] v);
        return (v != 16'h0000) && ((v & (v - 16'h0001)) == 16'h0000);
    endfunction

endpackage

// File: rtl/keypad_fifo.sv
// Small synchronous FIFO buffering accepted keystrokes.
//   clk, pb_reset : clock, asynchronous active-high reset (empties the FIFO)
//   push, din     : write request and data; dropped when full unless popping
//   pop           : read request; ignored when empty
//   full, empty   : occupancy flags
//   head          : oldest entry (undefined content when empty)
module keypad_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             pb_reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // A pop in the same cycle frees the slot the push lands in.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer registers.
    always_ff @(posedge clk or posedge pb_reset) begin
        if (pb_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage; content is don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with sweep debounce and keystroke FIFO.
//   clk, pb_reset : 100 MHz clock, asynchronous active-high reset
//   col_n         : active-low one-hot column drive
//   row_n         : active-low row sense (asynchronous, pulled up)
//   key_code      : oldest buffered key code, 0x00 when empty
//   key_present   : at least one keystroke buffered
//   read_key_ack  : single-cycle pop request
//   key_overflow  : sticky, a keystroke was dropped on a full FIFO
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 25000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                  clk,
    input  logic                  pb_reset,
    output logic [3:0]            col_n,
    input  logic [3:0]            row_n,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_present,
    input  logic                  read_key_ack,
    output logic                  key_overflow
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    logic [3:0]            row_meta;
    logic [3:0]            row_sync;
    logic [3:0]            pressed;

    scan_state_t           state,      state_d;
    key_state_t            kstate,     kstate_d;
    logic [1:0]            col,        col_d;
    logic [DIV_W-1:0]      div,        div_d;
    logic [15:0]           snapshot,   snap_d;
    logic [15:0]           prev_snap,  prev_d;
    logic [CNT_W-1:0]      stable_cnt, cnt_d;
    logic [3:0]            col_n_d;
    logic                  ovf_d;
    logic                  stable;
    logic                  push;
    logic [KEY_CODE_W-1:0] push_code;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [KEY_CODE_W-1:0] fifo_head;

    // Two-flop synchronizer; idle rows read as released.
    always_ff @(posedge clk or posedge pb_reset) begin
        if (pb_reset) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row_n;
            row_sync <= row_meta;
        end
    end

    assign pressed = ~row_sync;

    // State registers for scan sequencer, debounce and key acceptance.
    always_ff @(posedge clk or posedge pb_reset) begin
        if (pb_reset) begin
            state        <= DRIVE;
            kstate       <= IDLE;
            col          <= '0;
            div          <= '0;
            snapshot     <= '0;
            prev_snap    <= '0;
            stable_cnt   <= '0;
            col_n        <= 4'b1110;
            key_overflow <= 1'b0;
        end else begin
            state        <= state_d;
            kstate       <= kstate_d;
            col          <= col_d;
            div          <= div_d;
            snapshot     <= snap_d;
            prev_snap    <= prev_d;
            stable_cnt   <= cnt_d;
            col_n        <= col_n_d;
            key_overflow <= ovf_d;
        end
    end

    // Next-state logic: column scan, sweep debounce, single-key acceptance.
    always_comb begin
        state_d   = state;
        kstate_d  = kstate;
        col_d     = col;
        div_d     = div;
        snap_d    = snapshot;
        prev_d    = prev_snap;
        cnt_d     = stable_cnt;
        stable    = 1'b0;
        push      = 1'b0;
        push_code = NO_KEY;

        case (state)
            // The SAMPLE cycle is the last count of the column period.
            DRIVE: begin
                div_d = div + DIV_W'(1);
                if (div == DIV_W'(SCAN_DIV - 2)) state_d = SAMPLE;
            end
            SAMPLE: begin
                div_d = '0;
                snap_d[{col, 2'b00} +: 4] = pressed;
                if (col == 2'd3) begin
                    state_d = EVAL;
                end else begin
                    col_d   = col + 2'd1;
                    state_d = DRIVE;
                end
            end
            EVAL: begin
                if (snapshot == prev_snap) begin
                    if (stable_cnt != CNT_W'(DEBOUNCE_SCANS)) cnt_d = stable_cnt + CNT_W'(1);
                end else begin
                    cnt_d = CNT_W'(1);
                end
                prev_d  = snapshot;
                stable  = (cnt_d == CNT_W'(DEBOUNCE_SCANS));
                col_d   = '0;
                state_d = DRIVE;
            end
            default: begin
                state_d = DRIVE;
                col_d   = '0;
                div_d   = '0;
            end
        endcase

        // Chords and ghosts are ignored; a held key must fully release first.
        if (stable) begin
            case (kstate)
                IDLE: begin
                    if (is_onehot16(snapshot)) begin
                        push      = 1'b1;
                        push_code = {4'h0, onehot16_index(snapshot)};
                        kstate_d  = HELD;
                    end
                end
                HELD: begin
                    if (snapshot == 16'h0000) kstate_d = IDLE;
                end
                default: kstate_d = IDLE;
            endcase
        end

        col_n_d = ~(4'b0001 << col_d);
    end

    // A successful pop clears the sticky flag; a same-cycle pop saves the push.
    always_comb begin
        ovf_d = key_overflow;
        if (read_key_ack && !fifo_empty) begin
            ovf_d = 1'b0;
        end else if (push && fifo_full) begin
            ovf_d = 1'b1;
        end
    end

    keypad_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (KEY_CODE_W)
    ) u_fifo (
        .clk      (clk),
        .pb_reset (pb_reset),
        .push     (push),
        .pop      (read_key_ack),
        .din      (push_code),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head)
    );

    // Decoded straight from FIFO registers; no path from row_n or the ack.
    assign key_present = !fifo_empty;
    assign key_code    = fifo_empty ? NO_KEY : fifo_head;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a modelled 4x4 key matrix.
module tb_keypad_scanner;

    localparam int SWEEP = 4 * 4 + 1;

    logic       clk = 1'b0;
    logic       pb_reset;
    logic       read_key_ack;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [7:0] key_code;
    logic       key_present;
    logic       key_overflow;

    logic [15:0] keys;
    logic [7:0]  exp_q[$];
    logic        exp_ovf;
    int          n_assert = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (2),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk          (clk),
        .pb_reset     (pb_reset),
        .col_n        (col_n),
        .row_n        (row_n),
        .key_code     (key_code),
        .key_present  (key_present),
        .read_key_ack (read_key_ack),
        .key_overflow (key_overflow)
    );

    // Matrix model: a closed key pulls its row low while its column is driven.
    always_comb begin
        row_n = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (!col_n[c]) begin
                for (int r = 0; r < 4; r++) begin
                    if (keys[4*c+r]) row_n[r] = 1'b0;
                end
            end
        end
    end

    // Scoreboard producer: a FIFO of depth 4 that drops and flags when full.
    task automatic model_push(input logic [7:0] code);
        if (exp_q.size() < 4) exp_q.push_back(code);
        else exp_ovf = 1'b1;
    endtask

    task automatic press_key(input int idx, input int sweeps);
        keys[idx] = 1'b1;
        model_push(8'(idx));
        repeat (sweeps * SWEEP) @(posedge clk);
        #1 keys[idx] = 1'b0;
        repeat (4 * SWEEP) @(posedge clk);
        #1;
    endtask

    task automatic ack_pulse();
        read_key_ack = 1'b1;
        @(posedge clk);
        #1 read_key_ack = 1'b0;
    endtask

    // Waits for col_n to newly become target; expects to be called at edge+1.
    task automatic wait_col_edge(input logic [3:0] target);
        int n;
        n = 0;
        while (col_n == target && n < 100) begin @(posedge clk); #1; n++; end
        while (col_n != target && n < 200) begin @(posedge clk); #1; n++; end
        n_assert++;
        if (col_n !== target) begin
            n_fail++;
            $display("FAIL wait_col: col_n=%b required %b within bound", col_n, target);
        end
    endtask

    // Scoreboard consumer: pop each expected code, then require empty.
    task automatic drain(input string tag);
        logic [7:0] exp;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            n_assert++;
            if (key_present !== 1'b1 || key_code !== exp) begin
                n_fail++;
                $display("FAIL %s_head: present=%b code=%h required 1/%h", tag, key_present, key_code, exp);
            end
            ack_pulse();
        end
        n_assert++;
        if (key_present !== 1'b0 || key_code !== 8'h00) begin
            n_fail++;
            $display("FAIL %s_empty: present=%b code=%h required 0/00", tag, key_present, key_code);
        end
    endtask

    task automatic test_reset();
        pb_reset = 1'b1; read_key_ack = 1'b0; keys = '0; exp_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_assert++;
        if (col_n !== 4'b1110 || key_present !== 1'b0 || key_code !== 8'h00 || key_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: col_n=%b present=%b code=%h ovf=%b required 1110/0/00/0",
                     col_n, key_present, key_code, key_overflow);
        end
        pb_reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_assert++;
        if (col_n !== 4'b1110) begin
            n_fail++;
            $display("FAIL col0_period: col_n=%b required 1110", col_n);
        end
        @(posedge clk);
        #1;
        n_assert++;
        if (col_n !== 4'b1101) begin
            n_fail++;
            $display("FAIL col1_step: col_n=%b required 1101", col_n);
        end
        repeat (3 * SWEEP) @(posedge clk);
        #1;
    endtask

    task automatic test_single_press();
        keys[6] = 1'b1;
        model_push(8'h06);
        repeat (4 * SWEEP) @(posedge clk);
        #1;
        n_assert++;
        if (key_present !== 1'b1 || key_code !== 8'h06) begin
            n_fail++;
            $display("FAIL single_push: present=%b code=%h required 1/06", key_present, key_code);
        end
        ack_pulse();
        void'(exp_q.pop_front());
        n_assert++;
        if (key_present !== 1'b0 || key_code !== 8'h00) begin
            n_fail++;
            $display("FAIL single_ack: present=%b code=%h required 0/00", key_present, key_code);
        end
        repeat (2 * SWEEP) @(posedge clk);
        #1 keys[6] = 1'b0;
        repeat (4 * SWEEP) @(posedge clk);
        #1;
        n_assert++;
        if (key_present !== 1'b0) begin
            n_fail++;
            $display("FAIL single_no_repeat: present=%b required 0", key_present);
        end
    endtask

    task automatic test_bounce_hold();
        for (int t = 0; t < 3; t++) begin
            keys[6] = ~keys[6];
            repeat (SWEEP) @(posedge clk);
            #1;
        end
        keys[6] = 1'b1;
        n_assert++;
        if (key_present !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_no_push: present=%b required 0", key_present);
        end
        model_push(8'h06);
        repeat (10 * SWEEP) @(posedge clk);
        #1 keys[6] = 1'b0;
        repeat (4 * SWEEP) @(posedge clk);
        #1;
        press_key(6, 4);
        drain("bounce");
    endtask

    task automatic test_chord();
        keys[0] = 1'b1; keys[15] = 1'b1;
        repeat (5 * SWEEP) @(posedge clk);
        #1;
        n_assert++;
        if (key_present !== 1'b0) begin
            n_fail++;
            $display("FAIL chord_no_push: present=%b required 0", key_present);
        end
        keys[15] = 1'b0;
        model_push(8'h00);
        repeat (4 * SWEEP) @(posedge clk);
        #1 keys[0] = 1'b0;
        repeat (4 * SWEEP) @(posedge clk);
        #1;
        drain("chord");
    endtask

    task automatic test_overflow();
        press_key(1, 4);
        press_key(4, 4);
        press_key(9, 4);
        press_key(12, 4);
        press_key(14, 4);
        n_assert++;
        if (key_overflow !== exp_ovf || exp_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: key_overflow=%b required 1", key_overflow);
        end
        n_assert++;
        if (key_present !== 1'b1 || key_code !== exp_q[0]) begin
            n_fail++;
            $display("FAIL ovf_head: present=%b code=%h required 1/%h", key_present, key_code, exp_q[0]);
        end
        ack_pulse();
        void'(exp_q.pop_front());
        exp_ovf = 1'b0;
        n_assert++;
        if (key_overflow !== exp_ovf) begin
            n_fail++;
            $display("FAIL ovf_clear: key_overflow=%b required 0", key_overflow);
        end
        drain("ovf");
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        press_key(2, 4);
        press_key(3, 4);
        press_key(5, 4);
        press_key(7, 4);
        press_key(8, 4);
        n_assert++;
        if (key_overflow !== 1'b1 || key_present !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: ovf=%b present=%b required 1/1", key_overflow, key_present);
        end
        n = 0;
        while (col_n !== 4'b1011 && n < 40) begin @(posedge clk); #1; n++; end
        #2 pb_reset = 1'b1;
        #1;
        n_assert++;
        if (col_n !== 4'b1110 || key_present !== 1'b0 || key_code !== 8'h00 || key_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_sweep: col_n=%b present=%b code=%h ovf=%b required 1110/0/00/0",
                     col_n, key_present, key_code, key_overflow);
        end
        exp_q.delete();
        exp_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1 pb_reset = 1'b0;
        repeat (4 * SWEEP) @(posedge clk);
        #1;
        n_assert++;
        if (key_present !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_empty: present=%b required 0", key_present);
        end
    endtask

    task automatic test_back_to_back();
        press_key(10, 4);
        press_key(11, 4);
        press_key(12, 4);
        press_key(15, 4);
        // Align the new press to a sweep start so its push lands at a known EVAL.
        wait_col_edge(4'b1110);
        keys[13] = 1'b1;
        wait_col_edge(4'b0111);
        wait_col_edge(4'b1110);
        wait_col_edge(4'b0111);
        repeat (4) @(posedge clk);
        #1 read_key_ack = 1'b1;
        @(posedge clk);
        #1 read_key_ack = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(8'h0D);
        n_assert++;
        if (key_present !== 1'b1 || key_overflow !== 1'b0 || key_code !== exp_q[0]) begin
            n_fail++;
            $display("FAIL push_pop: present=%b ovf=%b code=%h required 1/0/%h",
                     key_present, key_overflow, key_code, exp_q[0]);
        end
        keys[13] = 1'b0;
        repeat (4 * SWEEP) @(posedge clk);
        #1;
        drain("push_pop");
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce_hold();
        test_chord();
        test_overflow();
        test_reset_mid_sweep();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
